// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage: registered in_ready, bubble-masked control,
// synchronous flush and a saturating count of consumed bubbles.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bubble,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic              in_ready_q,  in_ready_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    logic acc;
    logic pop;
    logic valid;

    assign valid = (state_q == ST_ONE) || (state_q == ST_FULL);
    assign acc   = in_valid & in_ready_q;
    assign pop   = valid & out_ready;

    always_comb begin
        state_d     = state_q;
        head_ctrl_d = head_ctrl_q;
        head_data_d = head_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        cnt_d       = cnt_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        head_ctrl_d = in_ctrl;
                        head_data_d = in_data;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && pop) begin
                        head_ctrl_d = in_ctrl;
                        head_data_d = in_data;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end else if (acc) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can move the stage
                    if (pop) begin
                        head_ctrl_d = skid_ctrl_q;
                        head_data_d = skid_data_q;
                        state_d     = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        in_ready_d = (state_d != ST_FULL);

        if (!valid && out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            head_ctrl_q <= '0;
            head_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            head_ctrl_q <= head_ctrl_d;
            head_data_q <= head_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = valid;
    assign out_bubble   = ~valid;
    assign out_ctrl     = valid ? head_ctrl_q : '0;
    assign out_data     = head_data_q;
    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a FIFO model of at most two entries
// is filled by the driver and drained/compared by an independent monitor.
module tb_pipe_stage_skid;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NW = 16;

    logic          clock = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic          out_bubble;
    logic [NW-1:0] bubble_count;

    logic          in_valid2  = 1'b0;
    logic          in_ready2;
    logic [CW-1:0] in_ctrl2   = '0;
    logic [DW-1:0] in_data2   = '0;
    logic          flush2     = 1'b0;
    logic          out_valid2;
    logic          out_ready2 = 1'b1;
    logic [CW-1:0] out_ctrl2;
    logic [DW-1:0] out_data2;
    logic          out_bubble2;
    logic [1:0]    bubble_count2;

    always #5 clock = ~clock;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .out_bubble(out_bubble), .bubble_count(bubble_count)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(2)) dut_sat (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_ctrl(in_ctrl2), .in_data(in_data2),
        .flush(flush2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_ctrl(out_ctrl2), .out_data(out_data2),
        .out_bubble(out_bubble2), .bubble_count(bubble_count2)
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   bub_m    = 0;
    bit   seen_edge;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Any edge while out of reset means in_ready should reflect occupancy.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) seen_edge <= 1'b0;
        else         seen_edge <= 1'b1;
    end

    task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input bit r, input bit f);
        ent_t e;
        @(posedge clock);
        #1;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        flush     = f;
        if (resetn && v && in_ready && !f) begin
            e.c = c;
            e.d = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input bit r);
        drive(1'b0, '0, '0, r, 1'b0);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (resetn) begin
                bit acc_now;
                int held;
                bit ev;
                acc_now = in_valid && in_ready && !flush;
                held    = exp_q.size() - (acc_now ? 1 : 0);
                ev      = (held > 0);
                chk("out_valid", 64'(out_valid), 64'(ev));
                chk("out_bubble", 64'(out_bubble), 64'(!ev));
                chk("in_ready", 64'(in_ready), 64'(seen_edge && held < 2));
                chk("bubble_count", 64'(bubble_count), 64'(bub_m));
                if (ev) begin
                    chk("out_data", out_data, exp_q[0].d);
                    chk("out_ctrl", 64'(out_ctrl), 64'(exp_q[0].c));
                end else begin
                    chk("out_ctrl_bubble", 64'(out_ctrl), 64'(0));
                end
                if (flush)                exp_q.delete();
                else if (ev && out_ready) void'(exp_q.pop_front());
                if (!ev && out_ready && bub_m < (1 << NW) - 1) bub_m++;
            end
        end
    end

    initial begin
        logic [NW-1:0] saved;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;

        // Idle after reset: in_ready rises after edge 1, bubbles counted, 2-bit counter saturates.
        for (int i = 1; i <= 6; i++) begin
            @(posedge clock);
            #1;
            chk("sat_count", 64'(bubble_count2), 64'((i < 3) ? i : 3));
            if (i == 1) chk("ready_after_reset", 64'(in_ready), 64'(1));
            if (i == 5) chk("idle_bubbles", 64'(bubble_count), 64'(5));
        end

        // Back-to-back stream 1,2,3.
        drive(1'b1, 8'h11, 64'd1, 1'b1, 1'b0);
        drive(1'b1, 8'h12, 64'd2, 1'b1, 1'b0);
        chk("stream_1", out_data, 64'd1);
        drive(1'b1, 8'h13, 64'd3, 1'b1, 1'b0);
        chk("stream_2", out_data, 64'd2);
        idle(1'b1);
        chk("stream_3", out_data, 64'd3);
        idle(1'b1);
        idle(1'b1);

        // Fill while stalled, then drain in order.
        drive(1'b1, 8'hA1, 64'hAAAA, 1'b0, 1'b0);
        drive(1'b1, 8'hB1, 64'hBBBB, 1'b0, 1'b0);
        idle(1'b0);
        chk("full_ready", 64'(in_ready), 64'(0));
        chk("full_head", out_data, 64'hAAAA);
        idle(1'b1);
        chk("drain_a", out_data, 64'hAAAA);
        idle(1'b1);
        chk("drain_b", out_data, 64'hBBBB);
        idle(1'b1);
        chk("drain_empty", 64'(out_valid), 64'(0));
        idle(1'b0);

        // Flush while full, with a simultaneous offer that must be dropped.
        drive(1'b1, 8'hC1, 64'hC1, 1'b0, 1'b0);
        drive(1'b1, 8'hC2, 64'hC2, 1'b0, 1'b0);
        drive(1'b1, 8'hC3, 64'hC3, 1'b0, 1'b1);
        saved = bubble_count;
        idle(1'b0);
        chk("flush_valid", 64'(out_valid), 64'(0));
        chk("flush_ctrl", 64'(out_ctrl), 64'(0));
        chk("flush_ready", 64'(in_ready), 64'(1));
        chk("flush_count", 64'(bubble_count), 64'(saved));

        // Asynchronous reset between edges while full.
        drive(1'b1, 8'hD1, 64'hD1, 1'b0, 1'b0);
        drive(1'b1, 8'hD2, 64'hD2, 1'b0, 1'b0);
        idle(1'b0);
        #2 resetn = 1'b0;
        exp_q.delete();
        bub_m = 0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_bubble", 64'(out_bubble), 64'(1));
        chk("rst_out_ctrl", 64'(out_ctrl), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_count", 64'(bubble_count), 64'(0));
        @(posedge clock);
        #1 resetn = 1'b1;
        repeat (4) begin
            idle(1'b1);
            chk("no_reappear", 64'(out_valid), 64'(0));
        end

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 2) != 0, CW'($urandom()), {$urandom(), $urandom()},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end
        repeat (4) idle(1'b1);
        chk("final_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
